// File: rtl/posit_pkg.sv
// Shared types and constants for the posit operation arbiter.
package posit_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } posit_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam int unsigned MAX_N = 64;

    // NaR is the posit "not a real" pattern: sign bit set, all other bits clear.
    function automatic logic [MAX_N-1:0] nar_word(input int unsigned n);
        return MAX_N'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/posit_rr_arb.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module posit_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/posit_op_arbiter.sv
// Shares one posit datapath between two requesters, one operation in flight,
// with a bounded wait that answers NaR plus an error flag on timeout.
module posit_op_arbiter
    import posit_pkg::*;
#(
    parameter int N       = 32,
    parameter int ES      = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][1:0]     req_op,
    input  logic [1:0][N-1:0]   req_a,
    input  logic [1:0][N-1:0]   req_b,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [N-1:0]        rsp_data,
    output logic                rsp_err,
    output logic                dp_start,
    output logic [1:0]          dp_op,
    output logic [N-1:0]        dp_a,
    output logic [N-1:0]        dp_b,
    input  logic                dp_done,
    input  logic [N-1:0]        dp_result
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [N-1:0] NAR = N'(nar_word(N));
    localparam int ES_UNUSED = ES;

    arb_state_t       state_q;
    logic             last_grant_q;
    logic             id_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [1:0]       rsp_valid_q;
    logic [N-1:0]     rsp_data_q;
    logic             rsp_err_q;
    logic             dp_start_q;
    logic [1:0]       dp_op_q;
    logic [N-1:0]     dp_a_q;
    logic [N-1:0]     dp_b_q;
    logic [1:0]       grant;
    logic             accept;
    logic             grant_id;

    posit_rr_arb u_rr_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign grant_id  = grant[1];
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            dp_start_q   <= 1'b0;
            dp_op_q      <= 2'b00;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
        end else begin
            dp_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        dp_op_q      <= req_op[grant_id];
                        dp_a_q       <= req_a[grant_id];
                        dp_b_q       <= req_b[grant_id];
                        dp_start_q   <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A completion in the final counted cycle still wins over the timeout.
                    if (dp_done) begin
                        rsp_data_q  <= dp_result;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= id_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q  <= NAR;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= id_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready[id_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign dp_start  = dp_start_q;
    assign dp_op     = dp_op_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;

endmodule

// File: tb/tb_posit_op_arbiter.sv
// Randomized bench for posit_op_arbiter: a datapath stub with chosen latency
// and a transaction-level model predicting grants, timing and responses.
module tb_posit_op_arbiter;
    import posit_pkg::*;

    localparam int N       = 32;
    localparam int TIMEOUT = 64;

    logic                clk;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][1:0]     req_op;
    logic [1:0][N-1:0]   req_a;
    logic [1:0][N-1:0]   req_b;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [N-1:0]        rsp_data;
    logic                rsp_err;
    logic                dp_start;
    logic [1:0]          dp_op;
    logic [N-1:0]        dp_a;
    logic [N-1:0]        dp_b;
    logic                dp_done;
    logic [N-1:0]        dp_result;

    int compared   = 0;
    int mismatched = 0;
    int lastServed = 1;

    posit_op_arbiter #(.N(N), .ES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dp_start  (dp_start),
        .dp_op     (dp_op),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_done   (dp_done),
        .dp_result (dp_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: lat = cycles from dp_start to dp_done (<=0 or >TIMEOUT
    // means the stub never answers in time), bp = cycles of response backpressure.
    task automatic applyStimulus(input logic [1:0] valids, input int lat, input int bp);
        posit_op_t    op [2];
        logic [N-1:0] a [2];
        logic [N-1:0] b [2];
        logic [N-1:0] res;
        logic [N-1:0] expData;
        logic         expErr;
        logic [1:0]   oh;
        int           expId;
        int           eff;

        for (int i = 0; i < 2; i++) begin
            op[i]     = posit_op_t'($urandom_range(0, 2));
            a[i]      = $urandom;
            b[i]      = $urandom;
            req_op[i] = op[i];
            req_a[i]  = a[i];
            req_b[i]  = b[i];
        end
        dp_done   = 1'b0;
        rsp_ready = 2'b00;
        req_valid = valids;

        if (valids == 2'b01)      expId = 0;
        else if (valids == 2'b10) expId = 1;
        else                      expId = 1 - lastServed;
        oh  = (expId == 1) ? 2'b10 : 2'b01;
        res = $urandom;
        if (lat >= 1 && lat <= TIMEOUT) begin
            eff = lat;  expErr = 1'b0; expData = res;
        end else begin
            eff = TIMEOUT; expErr = 1'b1; expData = {1'b1, {(N-1){1'b0}}};
        end

        @(negedge clk);
        checkOutput("rsp_valid_idle", rsp_valid, 2'b00);
        checkOutput("req_ready_grant", req_ready, oh);
        tick();
        lastServed = expId;

        for (int c = 1; c <= eff + 1; c++) begin
            dp_done   = (c == lat + 1);
            dp_result = (c == lat + 1) ? res : N'($urandom);
            @(negedge clk);
            checkOutput("dp_start", dp_start, (c == 1));
            checkOutput("dp_op", dp_op, op[expId]);
            checkOutput("dp_a", dp_a, a[expId]);
            checkOutput("dp_b", dp_b, b[expId]);
            checkOutput("req_ready_busy", req_ready, 2'b00);
            checkOutput("rsp_valid_early", rsp_valid, 2'b00);
            tick();
        end

        for (int k = 0; k <= bp; k++) begin
            rsp_ready = (k == bp) ? oh : ~oh;
            dp_done   = $urandom_range(0, 1);
            dp_result = $urandom;
            @(negedge clk);
            checkOutput("rsp_valid", rsp_valid, oh);
            checkOutput("rsp_data", rsp_data, expData);
            checkOutput("rsp_err", rsp_err, expErr);
            checkOutput("req_ready_resp", req_ready, 2'b00);
            tick();
        end
        dp_done   = 1'b0;
        rsp_ready = 2'b00;
        req_valid = 2'b00;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, req_ready, 2'b00);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 2'b00);
        checkOutput({tag, "_rsp_data"}, rsp_data, '0);
        checkOutput({tag, "_rsp_err"}, rsp_err, 1'b0);
        checkOutput({tag, "_dp_start"}, dp_start, 1'b0);
        checkOutput({tag, "_dp_op"}, dp_op, 2'b00);
        checkOutput({tag, "_dp_a"}, dp_a, '0);
        checkOutput({tag, "_dp_b"}, dp_b, '0);
    endtask

    // Abandon an operation in WAIT with an asynchronous reset, then send a stray dp_done.
    task automatic resetMidOp();
        req_op[0]  = OP_MUL;
        req_a[0]   = $urandom;
        req_b[0]   = $urandom;
        req_valid  = 2'b01;
        rsp_ready  = 2'b00;
        dp_done    = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_grant", req_ready, 2'b01);
        tick();
        lastServed = 0;
        req_valid  = 2'b00;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checkResetOutputs("rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        lastServed = 1;
        dp_done    = 1'b1;
        dp_result  = $urandom;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_stray_rsp_valid", rsp_valid, 2'b00);
            checkOutput("rst_stray_dp_start", dp_start, 1'b0);
            tick();
            dp_done = 1'b0;
        end
    endtask

    initial begin
        int r;
        int lat;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;
        dp_done   = 1'b0;
        dp_result = '0;
        #12;
        checkResetOutputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] contention from reset, alternating grants");
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, 2, 0);

        $display("[TB] single request, latency 3");
        applyStimulus(2'b01, 3, 0);

        $display("[TB] timeout and boundary cases");
        applyStimulus(2'b01, -1, 0);
        applyStimulus(2'b10, TIMEOUT, 0);
        applyStimulus(2'b01, TIMEOUT + 1, 1);
        applyStimulus(2'b10, 0, 0);

        $display("[TB] response backpressure");
        applyStimulus(2'b10, 4, 10);

        $display("[TB] reset during WAIT");
        resetMidOp();
        applyStimulus(2'b11, 1, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       lat = $urandom_range(1, 6);
            else if (r == 8) lat = TIMEOUT;
            else             lat = -1;
            applyStimulus(2'($urandom_range(1, 3)), lat, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/posit_op_arbiter.md
POSIT_OP_ARBITER -- requirements
Module: posit_op_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning posit word width.
REQ-002 SHALL have parameter ES, default 2, meaning posit exponent field width.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles before an error response.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 2, per-requester request valid.
REQ-007 SHALL have port req_ready, output, 2, per-requester request accept.
REQ-008 SHALL have port req_op, input, 2x2, per-requester opcode (posit_op_t).
REQ-009 SHALL have port req_a / req_b, input, 2xN each, per-requester posit operands.
REQ-010 SHALL have port rsp_valid, output, 2, per-requester response valid.
REQ-011 SHALL have port rsp_ready, input, 2, per-requester response accept.
REQ-012 SHALL have port rsp_data, output, N, result shared by both requesters, qualified by rsp_valid.
REQ-013 SHALL have port rsp_err, output, 1, timeout flag qualified by rsp_valid.
REQ-014 SHALL have port dp_start, output, 1, one-cycle start pulse to the shared posit datapath.
REQ-015 SHALL have port dp_op/dp_a/dp_b, output, 2/N/N, registered operands to the datapath, stable from dp_start until completion.
REQ-016 SHALL have port dp_done, input, 1, datapath completion pulse.
REQ-017 SHALL have port dp_result, input, N, datapath result (rounded, sign applied), valid with dp_done.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 In IDLE, SHALL grant one requester round-robin: a single valid requester wins; if both are valid, the requester not granted last wins.
REQ-020 SHALL assert req_ready combinationally only in IDLE and only for the granted requester; at most one bit set.
REQ-021 On req_valid&req_ready, SHALL register op/a/b and the grant ID, update last_grant, and go to ISSUE.
REQ-022 In ISSUE, SHALL assert dp_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 In WAIT, SHALL capture dp_result with rsp_err=0 on dp_done and go to RESP.
REQ-024 In WAIT, SHALL increment the timeout counter each cycle without dp_done; when it reaches TIMEOUT-1, SHALL load NaR (MSB 1, rest 0) with rsp_err=1 and go to RESP.
REQ-025 SHALL give dp_done priority over timeout when both occur in the same cycle.
REQ-026 SHALL ignore dp_done in IDLE, ISSUE and RESP.
REQ-027 In RESP, SHALL hold rsp_valid[id]=1 with stable rsp_data/rsp_err until rsp_ready[id]; on handshake, SHALL return to IDLE; rsp_ready of the other requester has no effect.
REQ-028 Latency: accept at cycle T gives dp_start at T+1; dp_done at T+1+L gives rsp_valid at T+2+L.
REQ-029 Throughput: one operation in flight; new grant no earlier than the cycle after the response handshake.
REQ-030 The timeout counter SHALL be $clog2(TIMEOUT)+1 bits and SHALL saturate, never wrap.

Reset
REQ-031 On rst, SHALL asynchronously enter IDLE.
REQ-032 On rst, SHALL drive req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, dp_start=0, dp_op/dp_a/dp_b=0, counter=0, last_grant=1 (requester 0 wins first).
REQ-033 Reset mid-operation SHALL abandon the operation with no response; a late dp_done after reset SHALL be ignored.

Structure
REQ-034 posit_pkg SHALL hold posit_op_t (OP_ADD=0, OP_SUB=1, OP_MUL=2), the arb_state_t enum and the NaR constant function of N.
REQ-035 The two-way round-robin grant SHALL be a sub-module posit_rr_arb (inputs req[1:0], last_grant; output grant[1:0]).

Verification
REQ-036 Single request: req0 ADD a=0x40000000 b=0x40000000, stub returns 0x48000000 after L=3 -> dp_start at T+1, rsp_valid[0] at T+5, data 0x48000000, err 0.
REQ-037 Contention: both requests valid from reset -> req0 served first, then req1; with both re-requesting, grants alternate 0,1,0,1.
REQ-038 Timeout: stub never asserts dp_done -> after 64 WAIT cycles, rsp_data=0x80000000, rsp_err=1.
REQ-039 Backpressure: rsp_ready[1]=0 for 10 cycles -> rsp_valid[1] and data held stable, req_ready stays 0, then the handshake returns the FSM to IDLE.
REQ-040 Reset in WAIT, then stray dp_done -> all outputs 0 and no rsp_valid; the next request completes normally.
REQ-041 Same-cycle dp_done and timeout at count 63 -> dp_result returned, err 0.
